// File: rtl/note_uart_tx.sv
`default_nettype none
// ============================================================================
// note_uart_tx : byte-FIFO-fronted UART transmitter (8N1, or 8E1 when
//                NOTE_UART_PARITY_EN is defined), LSB first, idle-high line.
// Revision     : 1.0
// ============================================================================
module note_uart_tx #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    localparam logic [CW-1:0]    DIV_LAST = CW'(DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    generate
        if (DIV < 2) begin : g_div_check
            $error("note_uart_tx: CLK_HZ / BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("note_uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef NOTE_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;
    logic             baud_done;
    logic             pop;
    logic             push;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

`ifdef NOTE_UART_PARITY_EN
    logic             parity_bit, parity_next;
`endif

    // Fullness is judged on the registered count, so a strobe that meets a
    // full FIFO is dropped even when the FSM frees a slot on the same edge.
    assign fifo_full = (count == DEPTH_C);
    assign push      = tx_start & ~fifo_full;
    assign busy      = (state != IDLE) | (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (tx_start && fifo_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
`ifdef NOTE_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
`ifdef NOTE_UART_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;
        tx_next    = 1'b1;
        baud_done  = (baud_cnt == DIV_LAST);
`ifdef NOTE_UART_PARITY_EN
        parity_next = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (count != '0) pop = 1'b1;
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef NOTE_UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef NOTE_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when work is queued.
                    if (count != '0) pop = 1'b1;
                    else             state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        if (pop) begin
            shift_next = fifo_mem[rd_ptr];
            baud_next  = '0;
            state_next = START;
`ifdef NOTE_UART_PARITY_EN
            parity_next = ^fifo_mem[rd_ptr];
`endif
        end

        // The line is registered, so drive it from where the FSM is heading.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef NOTE_UART_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_note_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_note_uart_tx : frame-level reference model plus literal spot checks.
// Revision        : 1.0
// ============================================================================
module tb_note_uart_tx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = CLK_HZ / BAUD;
`ifdef NOTE_UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = (PAR ? 11 : 10) * DIV;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx, busy, fifo_full, overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    note_uart_tx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx       (tx),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of waiting bytes and the byte/offset of the frame on the wire.
    logic [7:0] q[$];
    logic       m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    logic       m_ovf    = 1'b0;
    int         m_pre;
    logic       m_full;

    function automatic logic exp_bit(input logic [7:0] b, input int pos);
        int slot;
        slot = pos / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (slot == 9 && PAR) return ^b;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_pre  = q.size();
            m_full = (m_pre == FIFO_DEPTH);
            if (m_active && m_pos != FRAME - 1) begin
                m_pos++;
            end else if (m_pre != 0) begin
                m_byte   = q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_active = 1'b0;
            end
            if (tx_start) begin
                if (m_full) m_ovf = 1'b1;
                else        q.push_back(tx_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("tx",        tx,        m_active ? exp_bit(m_byte, m_pos) : 1'b1);
            check("busy",      busy,      m_active || (q.size() != 0));
            check("fifo_full", fifo_full, q.size() == FIFO_DEPTH);
            check("overflow",  overflow,  m_ovf);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            step(1);
            t++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        // 8'h05: start, then 1,0,1,0,0,0,0,0, (parity 0), stop
        push(8'h05);
        check("h05_k0_tx", tx, 1'b1);
        check("h05_k0_busy", busy, 1'b1);
        step(6);  check("h05_start", tx, 1'b0);
        step(9);  check("h05_b0", tx, 1'b1);
        step(10); check("h05_b1", tx, 1'b0);
        step(10); check("h05_b2", tx, 1'b1);
        step(10); check("h05_b3", tx, 1'b0);
        step(50); check("h05_k95", tx, PAR ? 1'b0 : 1'b1);
        step(FRAME - 95); check("h05_busy_last", busy, 1'b1);
        step(1);  check("h05_busy_fall", busy, 1'b0);

        // Burst of six: byte 05 is dropped
        for (int i = 0; i < 6; i++) push(8'(i));
        check("burst_full", fifo_full, 1'b1);
        check("burst_ovf", overflow, 1'b1);
        wait_idle();

        do_reset();
        check("ovf_cleared", overflow, 1'b0);
        push(8'hFF);
        step(15); check("ff_b0", tx, 1'b1);
        step(40); check("ff_b4", tx, 1'b1);
        step(30); check("ff_b7", tx, 1'b1);
        step(10); check("ff_k95", tx, PAR ? 1'b0 : 1'b1);
        wait_idle();

        // Strobe while full on the STOP->START pop edge
        do_reset();
        push(8'h3C);
        push(8'h81);
        push(8'h7E);
        push(8'hC3);
        push(8'h5A);
        check("popfull_full", fifo_full, 1'b1);
        step(FRAME - 4);
        check("popfull_full_pre", fifo_full, 1'b1);
        check("popfull_ovf_pre", overflow, 1'b0);
        push(8'h99);
        check("popfull_ovf", overflow, 1'b1);
        check("popfull_full_post", fifo_full, 1'b0);
        wait_idle();

        // Reset in the middle of a 0 data bit
        push(8'hA5);
        step(25);
        check("mid_bit1", tx, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("async_tx", tx, 1'b1);
        check("async_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(8'h42);
        check("post_rst_k0", tx, 1'b1);
        step(1);
        check("post_rst_start", tx, 1'b0);
        wait_idle();

        // Simultaneous push and pop with two queued
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step(FRAME - 2);
        push(8'h44);
        check("pushpop_full", fifo_full, 1'b0);
        check("pushpop_busy", busy, 1'b1);
        wait_idle();

        // Random traffic: sparse then dense
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 1500; i++) begin
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
        tx_start = 1'b0;
        wait_idle();
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_uart_tx.md
# note_uart_tx

Serial back end of the piano path: accepts note bytes from the note sender / one-second rate limiter (`tx_data`/`tx_start` byte strobe) and transmits them as 8N1 UART frames (8E1 when parity is compiled in) to the external synthesizer. A small FIFO absorbs bursts while a frame is in flight. Excess bytes are dropped and flagged, never stalled. LSB first, idle-high line.

## Interface
- `CLK_HZ`, 25_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate.
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only when `tx_start`=1.
- `tx_start`  in  1  single-cycle write strobe.
- `tx`  out  1  UART serial line, registered.
- `busy`  out  1  1 while FIFO is non-empty or a frame is in progress.
- `fifo_full`  out  1  1 when FIFO count == `FIFO_DEPTH`.
- `overflow`  out  1  sticky; set when a strobe is dropped.

## Operation
- `DIV = CLK_HZ / BAUD`, truncating integer division; must be ≥2 (elaboration error otherwise). The baud counter is `$clog2(DIV)` bits wide and counts 0..DIV-1.
- FIFO write rule:
  - `tx_start`=1 and count < `FIFO_DEPTH` → byte written.
  - `tx_start`=1 and count == `FIFO_DEPTH` → byte discarded and `overflow`<=1.
  - "Full" uses the registered count at the start of the cycle. A write while full is dropped even if the FSM pops in the same cycle.
  - Simultaneous push and pop with a non-full FIFO is legal; count is unchanged.
- Every byte value is transmitted verbatim, including 8'hFF (the "no key" code).
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty: pop into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for DIV cycles, then DATA.
  - DATA: `tx`=shift[0]; shift right after each DIV-cycle bit; after 8 bits go to PARITY or STOP.
  - PARITY: compiled-in only; `tx`=^byte, i.e. even parity, for DIV cycles; then STOP.
  - STOP: `tx`=1 for DIV cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- `busy` = (state != IDLE) | (count != 0).
- Reset mid-frame: the line returns to 1 immediately (async), the FIFO is emptied, and the partial frame is abandoned.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `overflow`=0, state IDLE, FIFO count 0, pointers 0.
- Latency, empty FIFO and IDLE:
  - `tx_start` sampled at edge N → FIFO write at edge N.
  - Pop, state<=START, and `tx`<=0 at edge N+1.
  - The start bit is visible from edge N+1.
- Frame length: 10·DIV cycles, or 11·DIV with parity.
- Back-to-back frames: next start bit begins on the edge immediately after the last stop-bit cycle.
- `fifo_full` and `busy` are derived from registered state and update on the same edge as the count.
- `overflow` is set on the edge that samples the dropped strobe; only `reset` clears it.

## Configuration
- `NOTE_UART_PARITY_EN` defined: PARITY state present; frame 8E1, 11·DIV cycles.
- `NOTE_UART_PARITY_EN` undefined: no PARITY state, and its logic is not synthesized; frame 8N1, 10·DIV cycles.

## Test plan
Bench uses CLK_HZ=1_000_000, BAUD=100_000, so DIV=10.

- Single byte 8'h05 strobed at cycle 0 → `tx` low during cycles 1–10, then bits 1,0,1,0,0,0,0,0 for 10 cycles each, then high. `busy` falls after 100 cycles from the start bit, plus 10 with parity.
- Six strobes on consecutive cycles (8'h00..8'h05) with FIFO_DEPTH=4 → bytes 00..04 transmitted back-to-back with no idle gap between stop and start. The first byte is popped before the fifth strobe arrives, so byte 05 is dropped and `overflow`=1.
- Byte 8'hFF → all eight data bits 1. With parity compiled in, the parity bit is 0 (even count of ones).
- Strobe while `fifo_full`=1 in the same cycle as a STOP→START pop → byte still dropped, `overflow`=1, and count goes from 4 to 3.
- `reset` asserted at mid-data-bit → `tx`=1 immediately and `busy`=0. The next strobe after release produces a clean frame starting one cycle later.
- Simultaneous push and pop with count=2 → count stays 2, and FIFO order is preserved (verified through serial readback).
